// File: rtl/nano_cpu_pkg.sv
// Shared opcode, funct3 and FSM definitions for the nano CPU dispatch slice.
package nano_cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // One in-flight destination slot
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
    } inflight_t;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/regfile.sv
// 31 x 32-bit register file: two read ports, a debug read port, one write port; x0 is hardwired zero.
module regfile
    import nano_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr1,
    output logic [XLEN-1:0]   rdata1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] regs [1:31];

    // Synchronous write; writes to x0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Combinational reads; a same-cycle write is seen only after the edge
    always_comb begin
        rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
        rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
        dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

endmodule

// File: rtl/alu_dispatch.sv
// Decode and issue RV32 OP / OP-IMM / LUI to an external 2-cycle ALU, track destinations, write back.
module alu_dispatch #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [31:0]      a_in,
    output logic [31:0]      b_in,
    output logic             in_valid,
    output logic [2:0]       funct3,
    output logic             funct3_valid,
    input  logic [31:0]      out,
    input  logic             out_valid,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    import nano_cpu_pkg::*;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic              is_op, is_imm, is_lui, is_sys;
    logic [XLEN-1:0]   rs1_data, rs2_data;
    logic [XLEN-1:0]   a_d, b_d;
    logic              f3v_d;
    logic              hazard_c, accept_c, issue_c, wb_en_c;
    logic [2:0]        f3_q;
    logic              f3v_q;
    inflight_t         s1_q, s2_q;
    state_e            state_q, state_d;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign is_op  = (opcode == OPC_OP);
    assign is_imm = (opcode == OPC_OP_IMM);
    assign is_lui = (opcode == OPC_LUI);
    assign is_sys = (opcode == OPC_SYSTEM);

    function automatic logic busy(input logic [REG_AW-1:0] r, input inflight_t a, input inflight_t b);
        return (r != '0) && ((a.valid && (a.rd == r)) || (b.valid && (b.rd == r)));
    endfunction

    // Stall on a source that is still being produced; no forwarding path exists
    always_comb begin
        hazard_c = ((is_op || is_imm) && busy(rs1, s1_q, s2_q)) ||
                   (is_op && busy(rs2, s1_q, s2_q));
    end

    assign instr_ready = (state_q == ST_RUN) && !hazard_c;
    assign accept_c    = instr_valid && instr_ready;
    assign issue_c     = accept_c && (is_op || is_imm || is_lui);
    assign wb_en_c     = out_valid && s2_q.valid;

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1   (rs1),
        .rdata1   (rs1_data),
        .raddr2   (rs2),
        .rdata2   (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_en_c),
        .waddr    (s2_q.rd),
        .wdata    (out)
    );

    // Operand selection per opcode class
    always_comb begin
        a_d   = '0;
        b_d   = '0;
        f3v_d = 1'b0;
        if (is_op) begin
            a_d   = rs1_data;
            b_d   = rs2_data;
            f3v_d = 1'b1;
        end else if (is_imm) begin
            a_d   = rs1_data;
            b_d   = sext12(instr[31:20]);
            f3v_d = 1'b1;
        end else if (is_lui) begin
            b_d   = {instr[31:12], 12'b0};
        end
    end

    // Issue registers; funct3 trails operands by one cycle to meet the ALU's operand stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_in         <= '0;
            b_in         <= '0;
            in_valid     <= 1'b0;
            f3_q         <= '0;
            f3v_q        <= 1'b0;
            funct3       <= '0;
            funct3_valid <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            in_valid     <= issue_c;
            illegal      <= accept_c && !(is_op || is_imm || is_lui || is_sys);
            funct3       <= f3_q;
            funct3_valid <= in_valid && f3v_q;
            if (issue_c) begin
                a_in  <= a_d;
                b_in  <= b_d;
                f3_q  <= instr[14:12];
                f3v_q <= f3v_d;
            end
        end
    end

    // Destination shift pipeline aligned with the ALU latency; stage 2 meets out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= '{valid: issue_c, rd: rd};
            s2_q <= s1_q;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (wb_en_c) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // FSM state register and halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == ST_HALTED);
        end
    end

    // FSM next state: SYSTEM drains in-flight work, then halts until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (accept_c && is_sys) state_d = ST_DRAIN;
            ST_DRAIN:  if (!s1_q.valid && !s2_q.valid) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch with a 2-cycle ALU model and an architectural reference model.
module tb_alu_dispatch;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      a_in, b_in;
    logic             in_valid;
    logic [2:0]       funct3;
    logic             funct3_valid;
    logic [31:0]      out;
    logic             out_valid;
    logic [4:0]       dbg_addr;
    logic [31:0]      dbg_data;
    logic             illegal;
    logic             halted;
    logic [CNT_W-1:0] retired;

    int n_cmp = 0;
    int n_fail = 0;

    alu_dispatch #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .in_valid     (in_valid),
        .funct3       (funct3),
        .funct3_valid (funct3_valid),
        .out          (out),
        .out_valid    (out_valid),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .illegal      (illegal),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // External ALU: operand stage registered, funct3 applied unregistered, result valid one cycle later
    logic [31:0] alu_a = '0, alu_b = '0;
    logic        alu_v = 1'b0;
    logic        spur  = 1'b0;
    always @(posedge clk) begin
        alu_a <= a_in;
        alu_b <= b_in;
        alu_v <= in_valid;
    end
    always_comb begin
        out       = funct3_valid ? ((funct3 == 3'b111) ? (alu_a & alu_b) : (alu_a + alu_b)) : alu_b;
        out_valid = alu_v | spur;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference model
    logic [31:0] m_reg [32];
    int unsigned m_ret;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_ret = 0;
    endtask

    task automatic model_exec(input logic [31:0] w);
        logic [31:0] s1, s2, imm, res;
        logic        wr;
        s1  = m_reg[w[19:15]];
        s2  = m_reg[w[24:20]];
        imm = {{20{w[31]}}, w[31:20]};
        wr  = 1'b1;
        case (w[6:0])
            7'b0010011: res = (w[14:12] == 3'b111) ? (s1 & imm) : (s1 + imm);
            7'b0110011: res = (w[14:12] == 3'b111) ? (s1 & s2) : (s1 + s2);
            7'b0110111: res = {w[31:12], 12'h000};
            default:    begin res = '0; wr = 1'b0; end
        endcase
        if (wr) begin
            m_ret++;
            if (w[11:7] != 5'd0) m_reg[w[11:7]] = res;
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input int rd, input int rs1, input logic [11:0] imm);
        return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [2:0] f3, input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lui(input int rd, input logic [19:0] imm);
        return {imm, 5'(rd), 7'b0110111};
    endfunction

    // funct3 follow-up checker: armed at acceptance, checks in_valid then funct3 one cycle later
    logic       arm_req = 1'b0, armed = 1'b0;
    logic       arm_f3v, exp_f3v;
    logic [2:0] arm_f3, exp_f3;
    always @(negedge clk) begin
        if (armed) begin
            chk("funct3_valid", 32'(funct3_valid), 32'(exp_f3v));
            if (exp_f3v) chk("funct3", 32'(funct3), 32'(exp_f3));
            armed = 1'b0;
        end
        if (arm_req) begin
            chk("in_valid_issue", 32'(in_valid), 32'd1);
            armed   = 1'b1;
            exp_f3v = arm_f3v;
            exp_f3  = arm_f3;
            arm_req = 1'b0;
        end
    end

    task automatic send(input logic [31:0] w, output int stall);
        stall = 0;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        #1;
        while (!instr_ready && stall < 40) begin
            @(negedge clk);
            #1;
            stall++;
        end
        if (!instr_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: instr %h never accepted", w);
            instr_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
            if (w[6:0] inside {7'b0010011, 7'b0110011, 7'b0110111}) begin
                arm_f3v = (w[6:0] != 7'b0110111);
                arm_f3  = w[14:12];
                arm_req = 1'b1;
            end
            model_exec(w);
        end
    endtask

    task automatic rd_reg(input int a, output logic [31:0] v);
        dbg_addr = 5'(a);
        #1;
        v = dbg_data;
    endtask

    task automatic chk_reg(input string name, input int a, input logic [31:0] exp);
        logic [31:0] v;
        rd_reg(a, v);
        chk(name, v, exp);
    endtask

    typedef struct {
        logic [31:0] w;
        int          stall;
        bit          drain;
        int          ca0;
        logic [31:0] cv0;
        int          ca1;
        logic [31:0] cv1;
        int          ret;
    } vec_t;

    vec_t vt [7];

    initial begin
        int          st;
        logic [31:0] w;
        bit          bad;
        int          cyc;

        vt[0] = '{enc_i(3'b000, 1, 0, 12'd5),    0, 1'b0, 0, 32'h0,         0, 32'h0,         0};
        vt[1] = '{enc_i(3'b000, 2, 0, 12'd7),    0, 1'b1, 1, 32'd5,         2, 32'd7,         2};
        vt[2] = '{enc_i(3'b000, 1, 0, 12'd5),    0, 1'b0, 0, 32'h0,         0, 32'h0,         0};
        vt[3] = '{enc_r(3'b000, 3, 1, 1),        2, 1'b1, 3, 32'd10,        1, 32'd5,         4};
        vt[4] = '{enc_lui(4, 20'hABCDE),         0, 1'b0, 0, 32'h0,         0, 32'h0,         0};
        vt[5] = '{enc_i(3'b111, 5, 4, 12'hFFF),  2, 1'b0, 0, 32'h0,         0, 32'h0,         0};
        vt[6] = '{enc_i(3'b000, 0, 0, 12'd9),    0, 1'b1, 5, 32'hABCDE000,  0, 32'h0,         7};

        model_reset();
        instr = '0;
        instr_valid = 1'b0;
        dbg_addr = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_in_valid", 32'(in_valid), 32'd0);
        chk("rst_a_in", a_in, 32'd0);
        chk("rst_b_in", b_in, 32'd0);
        chk("rst_f3v", 32'(funct3_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table: back-to-back issue, RAW stalls, LUI, ANDI, x0 write
        for (int i = 0; i < 7; i++) begin
            send(vt[i].w, st);
            chk($sformatf("stall_v%0d", i), 32'(st), 32'(vt[i].stall));
            if (vt[i].drain) begin
                repeat (3) @(negedge clk);
                chk_reg($sformatf("reg_a_v%0d", i), vt[i].ca0, vt[i].cv0);
                chk_reg($sformatf("reg_b_v%0d", i), vt[i].ca1, vt[i].cv1);
                chk($sformatf("retired_v%0d", i), 32'(retired), 32'(vt[i].ret));
            end
        end
        chk_reg("lui_x4", 4, 32'hABCDE000);

        // Illegal opcode: one-cycle pulse, no ALU issue, no retire
        send(32'h0000_0000, st);
        chk("illegal_pulse", 32'(illegal), 32'd1);
        chk("illegal_no_issue", 32'(in_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("illegal_cleared", 32'(illegal), 32'd0);
        repeat (2) @(negedge clk);
        chk("illegal_no_retire", 32'(retired), 32'd7);

        // Randomised program over a small register window to provoke hazards
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 4))
                0: w = enc_i(3'b000, $urandom_range(0, 7), $urandom_range(0, 7), 12'($urandom));
                1: w = enc_i(3'b111, $urandom_range(0, 7), $urandom_range(0, 7), 12'($urandom));
                2: w = enc_r(3'b000, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                3: w = enc_r(3'b111, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                default: w = enc_lui($urandom_range(0, 7), 20'($urandom));
            endcase
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(w, st);
        end
        repeat (4) @(negedge clk);
        for (int r = 0; r < 32; r++) chk_reg($sformatf("rand_x%0d", r), r, m_reg[r]);
        chk("rand_retired", 32'(retired), m_ret & 32'hFFFF);

        // SYSTEM behind two ADDIs: both retire, then halt with ready held low
        send(enc_i(3'b000, 8, 0, 12'd11), st);
        send(enc_i(3'b000, 9, 0, 12'd22), st);
        send(32'h0000_0073, st);
        chk("drain_ready", 32'(instr_ready), 32'd0);
        instr = enc_i(3'b000, 10, 0, 12'd1);
        instr_valid = 1'b1;
        bad = 1'b0;
        cyc = 0;
        while (!halted && cyc < 10) begin
            @(negedge clk);
            bad |= instr_ready;
            cyc++;
        end
        chk("halted_set", 32'(halted), 32'd1);
        repeat (3) begin
            @(negedge clk);
            bad |= instr_ready | !halted;
        end
        chk("halt_ready_low", 32'(bad), 32'd0);
        instr_valid = 1'b0;
        chk_reg("halt_x8", 8, 32'd11);
        chk_reg("halt_x9", 9, 32'd22);
        chk_reg("halt_x10", 10, m_reg[10]);
        chk("halt_retired", 32'(retired), m_ret & 32'hFFFF);

        // Reset leaves HALTED; then reset again with two ADDIs in flight
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_exit_halted", 32'(halted), 32'd0);
        send(enc_i(3'b000, 6, 0, 12'd3), st);
        send(enc_i(3'b000, 7, 0, 12'd4), st);
        rst_n = 1'b0;
        arm_req = 1'b0;
        armed = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spur = 1'b1;
        @(posedge clk);
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        chk_reg("midrst_x6", 6, 32'd0);
        chk_reg("midrst_x7", 7, 32'd0);
        chk("midrst_retired", 32'(retired), 32'd0);
        chk("midrst_ready", 32'(instr_ready), 32'd1);
        chk("midrst_halted", 32'(halted), 32'd0);
        send(enc_i(3'b000, 6, 0, 12'd3), st);
        repeat (3) @(negedge clk);
        chk_reg("post_rst_x6", 6, 32'd3);
        chk("post_rst_retired", 32'(retired), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port instr, input, 32, RV32 instruction word.
REQ-005 SHALL have port instr_valid, input, 1, instr holds a valid word.
REQ-006 SHALL have port instr_ready, output, 1, instr accepted when instr_valid && instr_ready.
REQ-007 SHALL have ALU-side outputs: a_in (32), b_in (32), in_valid (1), funct3 (3), funct3_valid (1).
REQ-008 SHALL have ALU-side inputs: out (32) and out_valid (1), the ALU result.
REQ-009 SHALL have port dbg_addr, input, 5, and dbg_data, output, 32: combinational register-file read, x0 reads 0.
REQ-010 SHALL have outputs illegal (1, one-cycle pulse), halted (1) and retired (CNT_W).

Function
REQ-011 SHALL hold 31 x 32-bit registers x1..x31; x0 reads 0 and writes to x0 are discarded.
REQ-012 SHALL decode OP-IMM (0010011) as a_in=rs1, b_in=sign-extended imm[11:0], funct3_valid=1, funct3=instr[14:12].
REQ-013 SHALL decode OP (0110011) as a_in=rs1, b_in=rs2, funct3_valid=1, funct3=instr[14:12]; funct7 ignored.
REQ-014 SHALL decode LUI (0110111) as a_in=0, b_in={instr[31:12],12'b0}, funct3_valid=0 (ALU passes b_in).
REQ-015 SHALL treat SYSTEM (1110011) as halt: accepted, no ALU issue, FSM to DRAIN.
REQ-016 SHALL accept any other opcode, issue nothing, and pulse illegal for one cycle after acceptance.
REQ-017 SHALL register a_in, b_in, in_valid: an instruction accepted at edge t drives in_valid=1 during cycle t..t+1.
REQ-018 SHALL drive funct3/funct3_valid one cycle after the matching in_valid, holding the values registered alongside it (ALU samples funct3 unregistered, aligned with its operand registers).
REQ-019 SHALL track in-flight destinations in a 2-stage {valid, rd} shift pipeline matching ALU latency 2; stage-2 valid SHALL coincide with out_valid.
REQ-020 SHALL write out to rd and increment retired (wrapping modulo 2^CNT_W) on each out_valid with stage-2 valid; out_valid without stage-2 valid is ignored.
REQ-021 SHALL deassert instr_ready when a valid in-flight rd (non-zero) equals a used rs1 (OP, OP-IMM) or rs2 (OP); no forwarding.
REQ-022 SHALL sustain one accepted instruction per cycle when no hazard and FSM in RUN.
REQ-023 SHALL make writeback and read of the same register in the same cycle return the old value (hazard rule guarantees no conflict).
REQ-024 SHALL implement FSM RUN -> DRAIN on accepted SYSTEM; DRAIN -> HALTED when both in-flight stages invalid; HALTED exits only by reset.
REQ-025 SHALL drive instr_ready=0 in DRAIN and HALTED; halted=1 only in HALTED.
REQ-026 SHALL count retired for ALU writebacks only (incl. rd=x0); SYSTEM and illegal do not count.

Reset
REQ-027 SHALL on rst_n=0 asynchronously clear all registers x1..x31, both in-flight stages, a_in, b_in, in_valid, funct3, funct3_valid, illegal, retired to 0 and FSM to RUN.
REQ-028 SHALL drop in-flight results on reset mid-operation; an out_valid arriving in the first cycle after release SHALL be ignored.

Structure
REQ-029 SHALL take opcode constants, FSM state encoding and funct3 values (ADD=000, AND=111) from a shared package nano_cpu_pkg.
REQ-030 SHALL place the register file in one sub-module regfile (two combinational read ports plus debug port, one synchronous write port).

Verification
REQ-031 SHALL cover: ADDI x1,x0,5 then ADDI x2,x0,7 -> retired=2, dbg x1=5, x2=7, ready high every cycle.
REQ-032 SHALL cover: ADDI x1,x0,5; ADD x3,x1,x1 -> ready low 2 cycles, then x3=10.
REQ-033 SHALL cover: LUI x4,0xABCDE -> funct3_valid=0 in the ALU cycle, x4=0xABCDE000.
REQ-034 SHALL cover: ANDI x5,x4,-1 (after LUI) -> funct3=111 one cycle after in_valid, x5=0xABCDE000; ADDI x0,x0,9 -> x0 reads 0, retired increments.
REQ-035 SHALL cover: opcode 0000000 -> illegal pulse, no in_valid; ECALL behind two ADDIs -> both retire, halted=1 after drain, ready stays 0.
REQ-036 SHALL cover: rst_n low while two ADDIs in flight -> no register written, retired=0, FSM RUN.
